// File: rtl/imem_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// imem_fetch_arbiter
//
// Shares the single-ported, read-only instruction memory between the pipeline
// fetch stage and a debug read port. A granted read holds the word-aligned
// address on mem_addr for RD_CYCLES cycles to cover the memory latency, then
// captures mem_data into the owner's data register and pulses the owner's
// valid for one cycle. A fetch flush during a fetch transaction lets the
// memory access finish but discards its result.
//
// Parameters:
//   RD_CYCLES    cycles the address is held before data is sampled (1..15)
//
// Ports:
//   CLK          clock, all state updates on the rising edge
//   Reset        synchronous, active-high reset
//   fetch_req    fetch read request (held by requester until granted)
//   fetch_addr   fetch byte address
//   fetch_gnt    fetch request accepted this cycle (combinational)
//   fetch_valid  one-cycle pulse, fetch_data is new
//   fetch_data   last fetch instruction word
//   dbg_req      debug read request (held by requester until granted)
//   dbg_addr     debug byte address
//   dbg_gnt      debug request accepted this cycle (combinational)
//   dbg_valid    one-cycle pulse, dbg_data is new
//   dbg_data     last debug word
//   flush        discard outstanding or same-cycle fetch transaction
//   mem_addr     word-aligned address to the instruction memory
//   mem_data     word returned by the instruction memory
//   busy         a transaction is occupying the memory
// ---------------------------------------------------------------------------
module imem_fetch_arbiter #(
    parameter int unsigned RD_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        fetch_req,
    input  logic [63:0] fetch_addr,
    output logic        fetch_gnt,
    output logic        fetch_valid,
    output logic [31:0] fetch_data,
    input  logic        dbg_req,
    input  logic [63:0] dbg_addr,
    output logic        dbg_gnt,
    output logic        dbg_valid,
    output logic [31:0] dbg_data,
    input  logic        flush,
    output logic [63:0] mem_addr,
    input  logic [31:0] mem_data,
    output logic        busy
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(RD_CYCLES - 1);

    state_t      state_q,       state_d;
    logic        prio_q,        prio_d;       // 1: debug wins a tie
    logic        owner_dbg_q,   owner_dbg_d;  // 1: debug owns the memory
    logic        kill_q,        kill_d;
    logic [3:0]  cnt_q,         cnt_d;
    logic [63:0] mem_addr_q,    mem_addr_d;
    logic [31:0] fetch_data_q,  fetch_data_d;
    logic [31:0] dbg_data_q,    dbg_data_d;
    logic        fetch_valid_q, fetch_valid_d;
    logic        dbg_valid_q,   dbg_valid_d;

    logic        fetch_cand;
    logic        dbg_cand;
    logic        kill_now;

    // Byte-offset bits never reach the memory; the port is word addressed.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^{fetch_addr[1:0], dbg_addr[1:0]};

    assign fetch_cand = fetch_req && !flush;
    assign dbg_cand   = dbg_req;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d       = state_q;
        prio_d        = prio_q;
        owner_dbg_d   = owner_dbg_q;
        kill_d        = kill_q;
        cnt_d         = cnt_q;
        mem_addr_d    = mem_addr_q;
        fetch_data_d  = fetch_data_q;
        dbg_data_d    = dbg_data_q;
        fetch_valid_d = 1'b0;
        dbg_valid_d   = 1'b0;
        fetch_gnt     = 1'b0;
        dbg_gnt       = 1'b0;
        kill_now      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Grants are withheld during reset so nothing is started that
                // the reset would immediately abort.
                if (!Reset) begin
                    if (fetch_cand && (!dbg_cand || !prio_q)) begin
                        fetch_gnt = 1'b1;
                    end else if (dbg_cand) begin
                        dbg_gnt = 1'b1;
                    end
                end

                if (fetch_gnt || dbg_gnt) begin
                    state_d     = WAIT;
                    owner_dbg_d = dbg_gnt;
                    prio_d      = fetch_gnt;   // round-robin: loser of this grant wins next tie
                    cnt_d       = CNT_LOAD;
                    kill_d      = 1'b0;
                    mem_addr_d  = fetch_gnt ? {fetch_addr[63:2], 2'b00}
                                            : {dbg_addr[63:2], 2'b00};
                end
            end

            WAIT: begin
                // A flush in the completion cycle itself must still kill the
                // response, so the live flush is folded in with the sticky flag.
                kill_now = kill_q || (flush && !owner_dbg_q);

                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                    kill_d  = 1'b0;
                    if (owner_dbg_q) begin
                        dbg_data_d  = mem_data;
                        dbg_valid_d = 1'b1;
                    end else if (!kill_now) begin
                        fetch_data_d  = mem_data;
                        fetch_valid_d = 1'b1;
                    end
                end else begin
                    cnt_d  = cnt_q - 4'd1;
                    kill_d = kill_now;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments keep every flop updating from the
        // same pre-edge values regardless of statement order.
        if (Reset) begin
            state_q       <= IDLE;
            prio_q        <= 1'b0;
            owner_dbg_q   <= 1'b0;
            kill_q        <= 1'b0;
            cnt_q         <= 4'd0;
            mem_addr_q    <= 64'd0;
            // NOTE: the data registers are reset too because their contents
            // are visible on the outputs straight after reset.
            fetch_data_q  <= 32'd0;
            dbg_data_q    <= 32'd0;
            fetch_valid_q <= 1'b0;
            dbg_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            prio_q        <= prio_d;
            owner_dbg_q   <= owner_dbg_d;
            kill_q        <= kill_d;
            cnt_q         <= cnt_d;
            mem_addr_q    <= mem_addr_d;
            fetch_data_q  <= fetch_data_d;
            dbg_data_q    <= dbg_data_d;
            fetch_valid_q <= fetch_valid_d;
            dbg_valid_q   <= dbg_valid_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign fetch_data  = fetch_data_q;
    assign dbg_data    = dbg_data_q;
    assign fetch_valid = fetch_valid_q;
    assign dbg_valid   = dbg_valid_q;
    assign busy        = (state_q == WAIT);

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// tb_imem_fetch_arbiter
//
// Two arbiter instances share all request inputs: dut_a with RD_CYCLES=2 and
// dut_b with RD_CYCLES=1. Each has its own ROM-backed memory. Directed tasks
// cover the documented scenarios; a randomized task compares both instances
// every cycle against a transaction-level reference model that tracks the
// grant cycle of the outstanding read and derives occupancy from elapsed time.
// ---------------------------------------------------------------------------
module tb_imem_fetch_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        fetch_req, dbg_req, flush;
    logic [63:0] fetch_addr, dbg_addr;

    logic        f_gnt_a, d_gnt_a, f_val_a, d_val_a, busy_a;
    logic [31:0] f_data_a, d_data_a, mem_data_a;
    logic [63:0] mem_addr_a;
    logic        f_gnt_b, d_gnt_b, f_val_b, d_val_b, busy_b;
    logic [31:0] f_data_b, d_data_b, mem_data_b;
    logic [63:0] mem_addr_b;

    logic [31:0] rom [64];
    assign mem_data_a = rom[mem_addr_a[7:2]];
    assign mem_data_b = rom[mem_addr_b[7:2]];

    int tests_run    = 0;
    int tests_failed = 0;

    imem_fetch_arbiter #(.RD_CYCLES(2)) dut_a (
        .CLK(clk), .Reset(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(f_gnt_a),
        .fetch_valid(f_val_a), .fetch_data(f_data_a),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(d_gnt_a),
        .dbg_valid(d_val_a), .dbg_data(d_data_a),
        .flush(flush), .mem_addr(mem_addr_a), .mem_data(mem_data_a), .busy(busy_a)
    );

    imem_fetch_arbiter #(.RD_CYCLES(1)) dut_b (
        .CLK(clk), .Reset(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(f_gnt_b),
        .fetch_valid(f_val_b), .fetch_data(f_data_b),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(d_gnt_b),
        .dbg_valid(d_val_b), .dbg_data(d_data_b),
        .flush(flush), .mem_addr(mem_addr_b), .mem_data(mem_data_b), .busy(busy_b)
    );

    // ---------------- reference model ----------------
    typedef struct {
        int          rd;
        bit          active;
        longint      gcyc;        // cycle in which the outstanding read was granted
        bit          own_dbg;
        logic [63:0] addr;
        bit          killed;
        bit          fetch_last;  // last grant went to fetch, so debug wins a tie
        logic [63:0] maddr;
        logic [31:0] fdata, ddata;
        bit          fval, dval;
    } model_t;

    model_t mdl [2];
    longint cyc;

    // The memory is free again from the cycle after the last sampling cycle.
    function automatic bit m_idle(model_t m, longint t);
        return !m.active || (t >= m.gcyc + longint'(m.rd) + 1);
    endfunction

    function automatic logic [1:0] m_gnt(model_t m, longint t);
        bit fc, dc, gf, gd;
        if (rst || !m_idle(m, t)) return 2'b00;
        fc = fetch_req && !flush;
        dc = dbg_req;
        gf = fc && (!dc || !m.fetch_last);
        gd = dc && !gf;
        return {gf, gd};
    endfunction

    function automatic model_t m_step(model_t m, longint t);
        model_t     n;
        logic [1:0] g;
        n = m;
        if (rst) begin
            n.active = 0; n.fetch_last = 0; n.killed = 0; n.maddr = '0;
            n.fdata = '0; n.ddata = '0; n.fval = 0; n.dval = 0;
            return n;
        end
        g = m_gnt(m, t);
        n.fval = 0;
        n.dval = 0;
        if (!m_idle(m, t)) begin
            if (flush && !m.own_dbg) n.killed = 1;
            if (t == m.gcyc + longint'(m.rd)) begin
                if (m.own_dbg) begin
                    n.ddata = rom[m.addr[7:2]];
                    n.dval  = 1;
                end else if (!n.killed) begin
                    n.fdata = rom[m.addr[7:2]];
                    n.fval  = 1;
                end
                n.active = 0;
            end
        end
        if (g != 2'b00) begin
            n.active     = 1;
            n.gcyc       = t;
            n.own_dbg    = g[0];
            n.addr       = (g[1] ? fetch_addr : dbg_addr) & ~64'h3;
            n.killed     = 0;
            n.maddr      = n.addr;
            n.fetch_last = g[1];
        end
        return n;
    endfunction

    // ---------------- helpers ----------------
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; fetch_req = 1'b0; dbg_req = 1'b0; flush = 1'b0;
        fetch_addr = '0; dbg_addr = '0;
        adv();
        adv();
        rst = 1'b0;
    endtask

    // ---------------- directed tests ----------------
    task automatic test_reset();
        rst = 1'b1; fetch_req = 1'b1; dbg_req = 1'b1; flush = 1'b0;
        fetch_addr = 64'h14; dbg_addr = 64'h30;
        adv();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            tests_run++;
            if ({f_gnt_a, d_gnt_a, f_gnt_b, d_gnt_b} !== 4'b0000) begin
                tests_failed++;
                $display("FAIL reset_gnt c%0d: got %b expected 0000", c, {f_gnt_a, d_gnt_a, f_gnt_b, d_gnt_b});
            end
            tests_run++;
            if ({busy_a, f_val_a, d_val_a, mem_addr_a, f_data_a, d_data_a} !== '0) begin
                tests_failed++;
                $display("FAIL reset_state c%0d: busy=%b fv=%b dv=%b maddr=%h fd=%h dd=%h expected all zero",
                         c, busy_a, f_val_a, d_val_a, mem_addr_a, f_data_a, d_data_a);
            end
            adv();
        end
        rst = 1'b0; fetch_req = 1'b0; dbg_req = 1'b0;
    endtask

    task automatic test_single_fetch();
        // {fetch_gnt, dbg_gnt, busy, fetch_valid} per cycle
        logic [3:0] ctl [5] = '{4'b1000, 4'b0010, 4'b0010, 4'b0001, 4'b0000};
        do_reset();
        fetch_addr = 64'h14;
        for (int c = 0; c < 5; c++) begin
            fetch_req = (c == 0);
            @(negedge clk);
            tests_run++;
            if ({f_gnt_a, d_gnt_a, busy_a, f_val_a} !== ctl[c]) begin
                tests_failed++;
                $display("FAIL single_ctl c%0d: got %b expected %b", c, {f_gnt_a, d_gnt_a, busy_a, f_val_a}, ctl[c]);
            end
            if (c == 1 || c == 2) begin
                tests_run++;
                if (mem_addr_a !== 64'h14) begin
                    tests_failed++;
                    $display("FAIL single_maddr c%0d: got %h expected 14", c, mem_addr_a);
                end
            end
            if (c == 3) begin
                tests_run++;
                if (f_data_a !== 32'hAA0B014A) begin
                    tests_failed++;
                    $display("FAIL single_data: got %h expected AA0B014A", f_data_a);
                end
            end
            adv();
        end
    endtask

    task automatic test_contention();
        do_reset();
        fetch_req = 1'b1; dbg_req = 1'b1; fetch_addr = 64'h0; dbg_addr = 64'h30;
        for (int c = 0; c < 8; c++) begin
            logic [1:0] eg;
            eg = (c == 0 || c == 6) ? 2'b10 : (c == 3) ? 2'b01 : 2'b00;
            @(negedge clk);
            tests_run++;
            if ({f_gnt_a, d_gnt_a} !== eg) begin
                tests_failed++;
                $display("FAIL contention_gnt c%0d: got %b expected %b", c, {f_gnt_a, d_gnt_a}, eg);
            end
            if (c == 3) begin
                tests_run++;
                if ({f_val_a, f_data_a} !== {1'b1, 32'hF84003E9}) begin
                    tests_failed++;
                    $display("FAIL contention_fetch: fv=%b fd=%h expected 1 F84003E9", f_val_a, f_data_a);
                end
            end
            if (c == 6) begin
                tests_run++;
                if ({d_val_a, d_data_a} !== {1'b1, 32'hF84203ED}) begin
                    tests_failed++;
                    $display("FAIL contention_dbg: dv=%b dd=%h expected 1 F84203ED", d_val_a, d_data_a);
                end
            end
            adv();
        end
        fetch_req = 1'b0; dbg_req = 1'b0;
    endtask

    task automatic test_flush_wait();
        do_reset();
        // load a known fetch_data value first
        fetch_req = 1'b1; fetch_addr = 64'h14;
        adv();
        fetch_req = 1'b0;
        adv();
        adv();
        // relative cycle 0: fetch at 0x28
        fetch_req = 1'b1; fetch_addr = 64'h28;
        @(negedge clk);
        tests_run++;
        if (f_gnt_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_wait_gnt: got %b expected 1", f_gnt_a);
        end
        adv();
        fetch_req = 1'b0; flush = 1'b1; dbg_req = 1'b1; dbg_addr = 64'h30;
        @(negedge clk);
        tests_run++;
        if ({busy_a, d_gnt_a} !== 2'b10) begin
            tests_failed++;
            $display("FAIL flush_wait_c1: busy/dgnt got %b expected 10", {busy_a, d_gnt_a});
        end
        adv();
        flush = 1'b0;
        @(negedge clk);
        tests_run++;
        if (busy_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_wait_busy: got %b expected 1", busy_a);
        end
        adv();
        @(negedge clk);
        tests_run++;
        if ({f_val_a, f_data_a, d_gnt_a} !== {1'b0, 32'hAA0B014A, 1'b1}) begin
            tests_failed++;
            $display("FAIL flush_wait_c3: fv=%b fd=%h dgnt=%b expected 0 AA0B014A 1", f_val_a, f_data_a, d_gnt_a);
        end
        adv();
        dbg_req = 1'b0;
        adv();
        adv();
        @(negedge clk);
        tests_run++;
        if ({d_val_a, d_data_a, f_val_a} !== {1'b1, 32'hF84203ED, 1'b0}) begin
            tests_failed++;
            $display("FAIL flush_wait_dbg: dv=%b dd=%h fv=%b expected 1 F84203ED 0", d_val_a, d_data_a, f_val_a);
        end
        adv();
    endtask

    task automatic test_flush_timing();
        do_reset();
        // flush in the sampling cycle still kills the response
        fetch_req = 1'b1; fetch_addr = 64'h0;
        adv();
        fetch_req = 1'b0;
        adv();
        flush = 1'b1;
        adv();
        flush = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({f_val_a, f_data_a} !== {1'b0, 32'h0}) begin
            tests_failed++;
            $display("FAIL flush_late: fv=%b fd=%h expected 0 00000000", f_val_a, f_data_a);
        end
        // flush in the valid cycle does not cancel that pulse
        fetch_req = 1'b1; fetch_addr = 64'h14;
        adv();
        fetch_req = 1'b0;
        adv();
        adv();
        flush = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({f_val_a, f_data_a} !== {1'b1, 32'hAA0B014A}) begin
            tests_failed++;
            $display("FAIL flush_valid_cycle: fv=%b fd=%h expected 1 AA0B014A", f_val_a, f_data_a);
        end
        adv();
        flush = 1'b0;
    endtask

    task automatic test_flush_idle();
        do_reset();
        fetch_req = 1'b1; dbg_req = 1'b1; flush = 1'b1;
        fetch_addr = 64'h0; dbg_addr = 64'h30;
        @(negedge clk);
        tests_run++;
        if ({f_gnt_a, d_gnt_a} !== 2'b01) begin
            tests_failed++;
            $display("FAIL flush_idle: gnt got %b expected 01", {f_gnt_a, d_gnt_a});
        end
        adv();
        fetch_req = 1'b0; dbg_req = 1'b0; flush = 1'b0;
    endtask

    task automatic test_misaligned_rd1();
        // {fetch_gnt, busy, fetch_valid} for dut_b per cycle
        logic [2:0] ctl [5] = '{3'b100, 3'b010, 3'b101, 3'b010, 3'b101};
        do_reset();
        fetch_req = 1'b1; fetch_addr = 64'h1F;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests_run++;
            if ({f_gnt_b, busy_b, f_val_b} !== ctl[c]) begin
                tests_failed++;
                $display("FAIL rd1_ctl c%0d: got %b expected %b", c, {f_gnt_b, busy_b, f_val_b}, ctl[c]);
            end
            if (c == 1) begin
                tests_run++;
                if (mem_addr_b !== 64'h1C) begin
                    tests_failed++;
                    $display("FAIL rd1_maddr: got %h expected 1C", mem_addr_b);
                end
            end
            if (c == 2) begin
                tests_run++;
                if (f_data_b !== rom[7]) begin
                    tests_failed++;
                    $display("FAIL rd1_data: got %h expected %h", f_data_b, rom[7]);
                end
            end
            adv();
        end
        fetch_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        dbg_req = 1'b1; dbg_addr = 64'h30;
        @(negedge clk);
        tests_run++;
        if (d_gnt_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_dgnt: got %b expected 1", d_gnt_a);
        end
        adv();
        rst = 1'b1; fetch_req = 1'b1; fetch_addr = 64'h14;
        @(negedge clk);
        tests_run++;
        if ({f_gnt_a, d_gnt_a} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_mid_gnt: got %b expected 00", {f_gnt_a, d_gnt_a});
        end
        adv();
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({busy_a, f_val_a, d_val_a, mem_addr_a, f_data_a, d_data_a} !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_state: busy=%b fv=%b dv=%b maddr=%h fd=%h dd=%h expected all zero",
                     busy_a, f_val_a, d_val_a, mem_addr_a, f_data_a, d_data_a);
        end
        tests_run++;
        if ({f_gnt_a, d_gnt_a} !== 2'b10) begin
            tests_failed++;
            $display("FAIL reset_mid_prio: gnt got %b expected 10", {f_gnt_a, d_gnt_a});
        end
        adv();
        fetch_req = 1'b0; dbg_req = 1'b0;
        for (int c = 3; c < 5; c++) begin
            @(negedge clk);
            tests_run++;
            if (d_val_a !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_mid_dval c%0d: got %b expected 0", c, d_val_a);
            end
            adv();
        end
    endtask

    // ---------------- randomized test ----------------
    task automatic test_random(int n);
        logic [132:0] act, exp;
        do_reset();
        cyc = 0;
        for (int k = 0; k < 2; k++) begin
            mdl[k] = '{rd: (k == 0) ? 2 : 1, active: 0, gcyc: 0, own_dbg: 0, addr: '0,
                       killed: 0, fetch_last: 0, maddr: '0, fdata: '0, ddata: '0,
                       fval: 0, dval: 0};
        end
        for (int i = 0; i < n; i++) begin
            rst        = ($urandom_range(0, 149) == 0);
            fetch_req  = ($urandom_range(0, 3) != 0);
            dbg_req    = ($urandom_range(0, 2) == 0);
            flush      = ($urandom_range(0, 6) == 0);
            fetch_addr = {$urandom(), $urandom()};
            dbg_addr   = {$urandom(), $urandom()};
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                exp = {m_gnt(mdl[k], cyc), mdl[k].fval, mdl[k].dval, !m_idle(mdl[k], cyc),
                       mdl[k].maddr, mdl[k].fdata, mdl[k].ddata};
                if (k == 0) act = {f_gnt_a, d_gnt_a, f_val_a, d_val_a, busy_a, mem_addr_a, f_data_a, d_data_a};
                else        act = {f_gnt_b, d_gnt_b, f_val_b, d_val_b, busy_b, mem_addr_b, f_data_b, d_data_b};
                tests_run++;
                if (act !== exp) begin
                    tests_failed++;
                    $display("FAIL random dut%0d cyc %0d: got %h expected %h (gnt2,val2,busy,maddr,fdata,ddata)",
                             k, cyc, act, exp);
                end
            end
            for (int k = 0; k < 2; k++) mdl[k] = m_step(mdl[k], cyc);
            adv();
            cyc++;
        end
        rst = 1'b0; fetch_req = 1'b0; dbg_req = 1'b0; flush = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = (32'(i) * 32'h9E3779B1) ^ 32'h13579BDF;
        rom[0]  = 32'hF84003E9;
        rom[5]  = 32'hAA0B014A;
        rom[12] = 32'hF84203ED;

        test_reset();
        test_single_fetch();
        test_contention();
        test_flush_wait();
        test_flush_timing();
        test_flush_idle();
        test_misaligned_rd1();
        test_reset_mid();
        test_random(3000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/imem_fetch_arbiter.md
# imem_fetch_arbiter

Sequencing and arbitration controller for the single-ported, read-only instruction memory. It shares the memory between the pipeline fetch stage and a debug/test-checker read port. Each granted read holds the memory address stable for a programmable number of cycles to cover the memory's read latency, then registers the returned word. It also supports a fetch flush that discards an in-flight fetch response after a branch redirect.

## Interface
Parameters:
- RD_CYCLES, default 2: cycles the address is held before data is sampled; legal range 1–15.

Ports:
- CLK, input, 1: clock; all state updates on the rising edge.
- Reset, input, 1: synchronous, active-high reset.
- fetch_req, input, 1: fetch requests a read.
- fetch_addr, input, 64: fetch byte address.
- fetch_gnt, output, 1: fetch request accepted this cycle.
- fetch_valid, output, 1: one-cycle pulse; fetch_data is new.
- fetch_data, output, 32: last fetch instruction word.
- dbg_req, input, 1: debug requests a read.
- dbg_addr, input, 64: debug byte address.
- dbg_gnt, output, 1: debug request accepted this cycle.
- dbg_valid, output, 1: one-cycle pulse; dbg_data is new.
- dbg_data, output, 32: last debug word.
- flush, input, 1: discard any outstanding or same-cycle fetch transaction.
- mem_addr, output, 64: address to the instruction memory.
- mem_data, input, 32: word returned by the instruction memory.
- busy, output, 1: a transaction is occupying the memory.

## Operation
- States: IDLE and WAIT.
- IDLE, arbitration:
  - Candidates are fetch_req && !flush, and dbg_req.
  - If only one candidate is present, it wins.
  - If both are present, the prio bit decides: prio=0 favours fetch, prio=1 favours debug.
  - The winner's gnt is combinational and high in the same cycle.
  - On the clock edge the block latches the address as {addr[63:2],2'b00}, records owner, loads cnt=RD_CYCLES-1, and moves to WAIT.
  - prio is set to 1 after a fetch grant and to 0 after a debug grant (round-robin).
  - At most one gnt is high in any cycle.
- WAIT:
  - mem_addr holds the latched address.
  - cnt decrements each cycle.
  - When cnt==0, mem_data is captured at the clock edge into the owner's data register, the owner's valid is pulsed the following cycle, and the state returns to IDLE.
- Flush:
  - Setting flush while owner=fetch in WAIT sets a kill flag.
  - The transaction runs to completion: the memory stays occupied and busy stays high.
  - At completion fetch_data is not updated and fetch_valid is not pulsed.
  - Flush has no effect on debug transactions.
  - Flush in IDLE suppresses the fetch grant for that cycle only.
- mem_addr holds its last value in IDLE.
- busy = (state==WAIT).
- Data registers hold their value until the next valid completion for that port.
- Reset, including mid-transaction:
  - state=IDLE, prio=0, kill=0, cnt=0, mem_addr=0, fetch_data=0, dbg_data=0, fetch_valid=0, dbg_valid=0.
  - An aborted transaction produces no valid pulse.
  - Requests are not granted in any cycle where Reset is high.

## Timing
- Grant in cycle t:
  - mem_addr shows the new address from cycle t+1.
  - Data is sampled at the end of cycle t+RD_CYCLES.
  - valid is high in cycle t+RD_CYCLES+1 only.
- The state is IDLE in the valid cycle, so a new grant is possible in cycle t+RD_CYCLES+1.
- Peak throughput is one word per RD_CYCLES+1 cycles.
- Requests that are not granted must be held by the requester. The arbiter does not queue them.
- RD_CYCLES=1: WAIT lasts exactly one cycle.
- Flush timing:
  - Flush asserted in the completion cycle (cnt==0) still kills the response.
  - Flush asserted in the valid cycle has no effect on that pulse.
- Requests that arrive during WAIT are ignored until IDLE.
- Simultaneous fetch_valid and dbg_valid is impossible.

## Test plan
- Single fetch, RD_CYCLES=2, memory loaded with the standard test program:
  - fetch_req, fetch_addr=0x14 in cycle 0 → fetch_gnt=1 in cycle 0.
  - mem_addr=0x14 in cycles 1–2.
  - fetch_valid=1 and fetch_data=0xAA0B014A in cycle 3.
  - busy high in cycles 1–2.
- Contention, both requests held continuously after reset:
  - fetch_addr=0x0, dbg_addr=0x30.
  - Grants alternate fetch, dbg, fetch at cycles 0, 3, 6.
  - fetch_data=0xF84003E9 and dbg_data=0xF84203ED.
- Flush mid-WAIT: fetch at 0x28 granted in cycle 0, flush pulsed in cycle 1:
  - No fetch_valid in cycle 3, and fetch_data keeps its prior value.
  - A debug request pending since cycle 1 is granted in cycle 3.
- Flush in IDLE with both requesting → dbg_gnt=1 and fetch_gnt=0 that cycle, regardless of prio.
- Misaligned and RD_CYCLES=1:
  - fetch_addr=0x1F with RD_CYCLES=1 → mem_addr=0x1C, and fetch_valid in cycle 2.
  - Back-to-back grants occur at cycles 0, 2, 4.
- Reset in cycle 1 of a debug transaction:
  - All outputs return to their reset values and no dbg_valid is produced.
  - After Reset is released, a held fetch_req is granted first (prio=0).
